// File: rtl/imem_program_loader.sv
// imem_program_loader: packs decoded MIPS instruction fields into imem words, then appends NOOP flush words
module imem_program_loader #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int PAD_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jaddr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);
  localparam int PW = $clog2(PAD_WORDS + 1);
  localparam logic [31:0]       NOOP     = 32'h6000_0019;
  localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [PW-1:0]     PAD_ONE  = PW'(1);
  localparam logic [PW-1:0]     PAD_LAST = PW'(PAD_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, addr_n;
  logic [ADDR_W:0]   remaining, rem_n;
  logic [PW-1:0]     pad_cnt, pad_n;
  logic              wrap_n, we_n, fire;
  logic [31:0]       wd_n, packed_word;

  // Field packing: R forces opcode 0, the unused fmt code encodes the NOOP word
  assign packed_word = in_fmt == 2'b00 ? {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct} :
                       in_fmt == 2'b01 ? {in_opcode, in_rs, in_rt, in_imm} :
                       in_fmt == 2'b10 ? {in_opcode, in_jaddr} : NOOP;

  // Session state and the registered write port; reset drops any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      pad_cnt   <= '0;
      wrapped   <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      remaining <= rem_n;
      pad_cnt   <= pad_n;
      wrapped   <= wrap_n;
      imem_we   <= we_n;
      imem_addr <= addr_n;
      imem_wd   <= wd_n;
    end
  end

  // Next-state and write selection; every accepted word or pad slot advances ptr modulo DEPTH
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    rem_n    = remaining;
    pad_n    = pad_cnt;
    wrap_n   = wrapped;
    we_n     = 1'b0;
    addr_n   = imem_addr;
    wd_n     = imem_wd;
    in_ready = (state == LOAD) && (remaining != '0);
    busy     = (state == LOAD) || (state == PAD);
    done     = (state == DONE);
    fire     = in_valid && in_ready;
    case (state)
      IDLE: if (start) begin
        ptr_n   = base_addr;
        rem_n   = count;
        pad_n   = '0;
        wrap_n  = 1'b0;
        state_n = count == '0 ? PAD : LOAD;
      end
      LOAD: if (fire) begin
        we_n    = 1'b1;
        addr_n  = ptr;
        wd_n    = packed_word;
        ptr_n   = ptr + PTR_ONE;
        wrap_n  = wrapped || (ptr == PTR_MAX);
        rem_n   = remaining - REM_ONE;
        state_n = remaining == REM_ONE ? PAD : LOAD;
      end
      PAD: begin
        we_n    = 1'b1;
        addr_n  = ptr;
        wd_n    = NOOP;
        ptr_n   = ptr + PTR_ONE;
        wrap_n  = wrapped || (ptr == PTR_MAX);
        pad_n   = pad_cnt + PAD_ONE;
        state_n = pad_cnt == PAD_LAST ? DONE : PAD;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: randomized sessions checked against a list-of-writes reference model
module tb_imem_program_loader;
  localparam int DEPTH = 64;
  localparam int PADW  = 4;
  localparam logic [31:0] NOOP = 32'h6000_0019;

  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [5:0]  base_addr = 0;
  logic [6:0]  count = 0;
  logic [1:0]  in_fmt = 0;
  logic [5:0]  in_opcode = 0, in_funct = 0;
  logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_jaddr = 0;
  logic        in_ready, imem_we, busy, done, wrapped;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wd;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(6), .PAD_WORDS(PADW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_jaddr(in_jaddr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .busy(busy), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;

  typedef struct { logic [5:0] a; logic [31:0] d; int t; } wr_t;
  wr_t obs[$];
  int  done_cnt = 0, done_busy = 0;

  // Write/done monitor, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    if (imem_we) obs.push_back('{imem_addr, imem_wd, cyc});
    if (done) begin
      done_cnt++;
      if (busy) done_busy++;
    end
  end

  logic [1:0]  f_fmt [64];
  logic [5:0]  f_op  [64], f_fn [64];
  logic [4:0]  f_rs  [64], f_rt [64], f_rd [64], f_sh [64];
  logic [15:0] f_imm [64];
  logic [25:0] f_ja  [64];
  int          acc_t [64];

  function automatic logic [31:0] model_word(int i);
    logic [31:0] w;
    case (f_fmt[i])
      2'd0: w = (32'(f_rs[i]) << 21) | (32'(f_rt[i]) << 16) | (32'(f_rd[i]) << 11) |
                (32'(f_sh[i]) << 6) | 32'(f_fn[i]);
      2'd1: w = (32'(f_op[i]) << 26) | (32'(f_rs[i]) << 21) | (32'(f_rt[i]) << 16) | 32'(f_imm[i]);
      2'd2: w = (32'(f_op[i]) << 26) | 32'(f_ja[i]);
      default: w = NOOP;
    endcase
    return w;
  endfunction

  task automatic rand_fields(input int n);
    for (int i = 0; i < n; i++) begin
      f_fmt[i] = 2'($urandom_range(0, 3));
      f_op[i]  = 6'($urandom);
      f_rs[i]  = 5'($urandom);
      f_rt[i]  = 5'($urandom);
      f_rd[i]  = 5'($urandom);
      f_sh[i]  = 5'($urandom);
      f_fn[i]  = 6'($urandom);
      f_imm[i] = 16'($urandom);
      f_ja[i]  = 26'($urandom);
    end
  endtask

  task automatic drive_fields(input int i);
    in_valid = 1; in_fmt = f_fmt[i]; in_opcode = f_op[i]; in_rs = f_rs[i]; in_rt = f_rt[i];
    in_rd = f_rd[i]; in_shamt = f_sh[i]; in_funct = f_fn[i]; in_imm = f_imm[i]; in_jaddr = f_ja[i];
  endtask

  task automatic drive_junk();
    in_valid = 0; in_fmt = 2'($urandom); in_opcode = 6'($urandom); in_rs = 5'($urandom);
    in_rt = 5'($urandom); in_rd = 5'($urandom); in_shamt = 5'($urandom); in_funct = 6'($urandom);
    in_imm = 16'($urandom); in_jaddr = 26'($urandom);
  endtask

  // One complete session: mode 0 = always valid, 1 = toggling valid, 2 = random valid
  task automatic run_session(input int base, input int n, input int mode, input bit poke);
    int idx, budget;
    bit v;
    obs.delete(); done_cnt = 0; done_busy = 0;
    @(negedge clk);
    start = 1; base_addr = 6'(base); count = 7'(n);
    @(negedge clk);
    start = 0; base_addr = 6'($urandom); count = 7'($urandom);
    total++;
    if (wrapped !== 1'b0 || busy !== 1'b1) $display("FAIL session_start: wrapped=%b busy=%b required wrapped=0 busy=1", wrapped, busy);
    else passed++;
    idx = 0; budget = 0;
    while (idx < n && budget < 500) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      if (v) drive_fields(idx); else drive_junk();
      if (in_valid && in_ready) begin
        acc_t[idx] = cyc;
        idx++;
      end
      @(negedge clk);
      budget++;
    end
    drive_junk();
    if (idx < n) begin
      total++;
      $display("FAIL accept_timeout: accepted %0d required %0d", idx, n);
    end else if (n > 0) begin
      total++;
      if (in_ready !== 1'b0) $display("FAIL ready_after_last: in_ready=%b required 0", in_ready);
      else passed++;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 50) begin
      start = poke && budget == 0;
      base_addr = 6'($urandom);
      count = 7'($urandom_range(1, 9));
      @(negedge clk);
      start = 0;
      budget++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== 1 || done_busy !== 0) $display("FAIL done_pulse: cycles=%0d with_busy=%0d required 1 and 0", done_cnt, done_busy);
    else passed++;
    total++;
    if (obs.size() !== n + PADW) $display("FAIL write_count: got %0d required %0d", obs.size(), n + PADW);
    else passed++;
    for (int i = 0; i < obs.size() && i < n + PADW; i++) begin
      logic [5:0]  ea;
      logic [31:0] ed;
      ea = 6'((base + i) % DEPTH);
      ed = i < n ? model_word(i) : NOOP;
      total++;
      if (obs[i].a !== ea || obs[i].d !== ed)
        $display("FAIL write[%0d]: got addr=%0d data=%h required addr=%0d data=%h", i, obs[i].a, obs[i].d, ea, ed);
      else passed++;
      total++;
      if (i < n ? obs[i].t !== acc_t[i] + 1 : (i > 0 && obs[i].t !== obs[i-1].t + 1))
        $display("FAIL write_timing[%0d]: at cycle %0d, previous reference %0d", i, obs[i].t, i < n ? acc_t[i] : obs[i > 0 ? i-1 : 0].t);
      else passed++;
    end
    total++;
    if (wrapped !== (base + n + PADW >= DEPTH)) $display("FAIL wrapped: got %b required %b", wrapped, base + n + PADW >= DEPTH);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wd, busy, done, wrapped} !== '0)
      $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d wd=%h busy=%b done=%b wrapped=%b required all 0",
               in_ready, imem_we, imem_addr, imem_wd, busy, done, wrapped);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_pack();
    rand_fields(4);
    f_fmt[0] = 2'd0; f_op[0] = 6'h3F; f_rs[0] = 5'd1; f_rt[0] = 5'd2; f_rd[0] = 5'd3; f_sh[0] = 5'd0; f_fn[0] = 6'h20;
    f_fmt[1] = 2'd1; f_op[1] = 6'h08; f_rs[1] = 5'd0; f_rt[1] = 5'd8; f_imm[1] = 16'hFFFF;
    f_fmt[2] = 2'd2; f_op[2] = 6'h03; f_ja[2] = 26'h10;
    f_fmt[3] = 2'd3;
    run_session(10, 4, 0, 0);
    if (obs.size() >= 4) begin
      total++;
      if (obs[0].d !== 32'h00221820) $display("FAIL pack_r: got %h required 00221820", obs[0].d); else passed++;
      total++;
      if (obs[1].d !== 32'h2008FFFF) $display("FAIL pack_i: got %h required 2008ffff", obs[1].d); else passed++;
      total++;
      if (obs[2].d !== 32'h0C000010) $display("FAIL pack_j: got %h required 0c000010", obs[2].d); else passed++;
      total++;
      if (obs[3].d !== NOOP) $display("FAIL pack_nop: got %h required 60000019", obs[3].d); else passed++;
    end
  endtask

  task automatic test_backpressure();
    rand_fields(3);
    run_session(5, 3, 1, 0);
  endtask

  task automatic test_wrap();
    rand_fields(4);
    run_session(62, 4, 2, 0);
    repeat (5) @(negedge clk);
    total++;
    if (wrapped !== 1'b1) $display("FAIL wrapped_sticky: got %b required 1", wrapped); else passed++;
  endtask

  task automatic test_count_zero();
    run_session(40, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 5; s++) begin
      int n;
      n = $urandom_range(1, 20);
      rand_fields(n);
      run_session($urandom_range(0, 63), n, 2, s[0]);
    end
  endtask

  task automatic test_reset_mid();
    rand_fields(5);
    @(negedge clk);
    start = 1; base_addr = 6'd20; count = 7'd5;
    @(negedge clk);
    start = 0;
    drive_fields(0);
    @(negedge clk);
    drive_fields(1);
    @(negedge clk);
    drive_fields(2);
    #2 rst_n = 0;
    #1;
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wd, busy, done, wrapped} !== '0)
      $display("FAIL reset_mid: got ready=%b we=%b addr=%0d wd=%h busy=%b done=%b wrapped=%b required all 0",
               in_ready, imem_we, imem_addr, imem_wd, busy, done, wrapped);
    else passed++;
    drive_junk();
    @(negedge clk);
    rst_n = 1;
    rand_fields(3);
    run_session(0, 3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pack();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
